// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier: one recoding step per RUN cycle, fixed latency.
// Define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH/2 steps); default build is radix-2.
module booth_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   // Two guard bits keep +/-2A on the most negative multiplicand representable.
   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 1);
`ifdef BOOTH_RADIX4_EN
   localparam int STEPS = WIDTH / 2;
`else
   localparam int STEPS = WIDTH;
`endif
   localparam logic [CW-1:0] N_LOAD = CW'(STEPS);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplr_q;
   logic [AW-1:0]    acc_q;
   logic             qm1_q;
   logic [CW-1:0]    cnt_q;

   logic [AW-1:0]    a_ext;
   logic [AW-1:0]    sum;
   logic [AW-1:0]    acc_nx;
   logic [WIDTH-1:0] mplr_nx;
   logic             qm1_nx;

   assign a_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};

`ifdef BOOTH_RADIX4_EN
   logic [AW-1:0] a_ext2;
   assign a_ext2 = {a_ext[AW-2:0], 1'b0};

   always_comb begin
      sum     = acc_q;
      acc_nx  = acc_q;
      mplr_nx = mplr_q;
      qm1_nx  = qm1_q;
      case ({mplr_q[1:0], qm1_q})
         3'b001, 3'b010: sum = acc_q + a_ext;
         3'b011:         sum = acc_q + a_ext2;
         3'b100:         sum = acc_q - a_ext2;
         3'b101, 3'b110: sum = acc_q - a_ext;
         default:        sum = acc_q;
      endcase
      acc_nx  = {{2{sum[AW-1]}}, sum[AW-1:2]};
      mplr_nx = {sum[1:0], mplr_q[WIDTH-1:2]};
      qm1_nx  = mplr_q[1];
   end
`else
   always_comb begin
      sum     = acc_q;
      acc_nx  = acc_q;
      mplr_nx = mplr_q;
      qm1_nx  = qm1_q;
      case ({mplr_q[0], qm1_q})
         2'b01:   sum = acc_q + a_ext;
         2'b10:   sum = acc_q - a_ext;
         default: sum = acc_q;
      endcase
      acc_nx  = {sum[AW-1], sum[AW-1:1]};
      mplr_nx = {sum[0], mplr_q[WIDTH-1:1]};
      qm1_nx  = mplr_q[0];
   end
`endif

   // RUN spends one extra cycle at count zero to write p, giving N+1 cycles to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         p       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q <= a;
                  mplr_q  <= b;
                  acc_q   <= '0;
                  qm1_q   <= 1'b0;
                  cnt_q   <= N_LOAD;
               end
            end
            RUN: begin
               if (cnt_q != '0) begin
                  acc_q  <= acc_nx;
                  mplr_q <= mplr_nx;
                  qm1_q  <= qm1_nx;
                  cnt_q  <= cnt_q - CW'(1);
               end else begin
                  p <= {acc_q[WIDTH-1:0], mplr_q};
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and small random checks of booth_seq_mult at WIDTH=4 and WIDTH=8.
// Expected latency follows BOOTH_RADIX4_EN when the bench is built with it.
module tb_booth_seq_mult;

`ifdef BOOTH_RADIX4_EN
   localparam int N4 = 2;
   localparam int N8 = 4;
`else
   localparam int N4 = 4;
   localparam int N8 = 8;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  p4;
   logic [15:0] p8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_seq_mult #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .p(p4)
   );

   booth_seq_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cur_done(input bit w8);
      return w8 ? done8 : done4;
   endfunction

   function automatic logic cur_busy(input bit w8);
      return w8 ? busy8 : busy4;
   endfunction

   function automatic logic [15:0] cur_p(input bit w8);
      return w8 ? p8 : {8'h00, p4};
   endfunction

   // Start one multiply, scramble operands during RUN, check latency, p and the done pulse.
   task automatic run_op(input bit w8, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp_p, input string tag);
      int          cyc;
      logic [15:0] p_before;
      logic        stable;
      @(posedge clk); #1;
      if (w8) begin a8 = x; b8 = y; start8 = 1'b1; end
      else    begin a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1; end
      @(posedge clk); #1;
      start8 = 1'b0;
      start4 = 1'b0;
      p_before = cur_p(w8);
      check({tag, ".busy"}, 32'(cur_busy(w8)), 32'd1);
      cyc = 0;
      stable = 1'b1;
      while (!cur_done(w8) && cyc < 40) begin
         if (w8) begin a8 = ~a8; b8 = b8 + 8'd37; end
         else    begin a4 = ~a4; b4 = b4 + 4'd5; end
         @(posedge clk); #1;
         cyc++;
         if (!cur_done(w8) && cur_p(w8) !== p_before) stable = 1'b0;
      end
      check({tag, ".lat"}, 32'(cyc), 32'(w8 ? N8 + 1 : N4 + 1));
      check({tag, ".p"}, 32'(cur_p(w8)), 32'(exp_p));
      check({tag, ".p_hold_run"}, 32'(stable), 32'd1);
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 32'(cur_done(w8)), 32'd0);
      check({tag, ".idle"}, 32'(cur_busy(w8)), 32'd0);
   endtask

   initial begin
      int              cyc;
      int              dones;
      logic [7:0]      rx, ry;
      logic signed [7:0]  sx, sy;
      logic signed [15:0] se;
      logic signed [3:0]  sx4, sy4;
      logic signed [7:0]  se4;

      rst_n = 1'b0;
      start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      #12;
      check("rst.busy4", 32'(busy4), 32'd0);
      check("rst.done4", 32'(done4), 32'd0);
      check("rst.p4", 32'(p4), 32'd0);
      check("rst.busy8", 32'(busy8), 32'd0);
      check("rst.done8", 32'(done8), 32'd0);
      check("rst.p8", 32'(p8), 32'd0);
      rst_n = 1'b1;

      // WIDTH=4 directed
      run_op(1'b0, 8'h09, 8'h01, 16'h00F9, "w4_m7x1");
      run_op(1'b0, 8'h05, 8'h08, 16'h00D8, "w4_5xm8");
      run_op(1'b0, 8'h08, 8'h08, 16'h0040, "w4_m8xm8");
      run_op(1'b0, 8'h07, 8'h07, 16'h0031, "w4_7x7");
      run_op(1'b0, 8'h08, 8'h07, 16'h00C8, "w4_m8x7");
      run_op(1'b0, 8'h0F, 8'h0F, 16'h0001, "w4_m1xm1");
      run_op(1'b0, 8'h00, 8'h08, 16'h0000, "w4_0xm8");

      // WIDTH=8 directed
      run_op(1'b1, 8'h80, 8'h80, 16'h4000, "w8_m128xm128");
      run_op(1'b1, 8'h7F, 8'h80, 16'hC080, "w8_127xm128");
      run_op(1'b1, 8'h7F, 8'h7F, 16'h3F01, "w8_127x127");
      run_op(1'b1, 8'h64, 8'h9C, 16'hD8F0, "w8_100xm100");
      run_op(1'b1, 8'hFF, 8'h01, 16'hFFFF, "w8_m1x1");

      // start held high across two WIDTH=4 operations
      @(posedge clk); #1;
      a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
      @(posedge clk); #1;
      check("hold.busy", 32'(busy4), 32'd1);
      cyc = 0;
      while (!done4 && cyc < 40) begin
         a4 = ~a4; b4 = ~b4;
         @(posedge clk); #1;
         cyc++;
      end
      check("hold1.lat", 32'(cyc), 32'(N4 + 1));
      check("hold1.p", 32'(p4), 32'h0F);
      a4 = 4'hE; b4 = 4'h3;
      @(posedge clk); #1;
      check("hold.idle_after_done", 32'(busy4), 32'd0);
      check("hold.done_low", 32'(done4), 32'd0);
      @(posedge clk); #1;
      start4 = 1'b0;
      check("hold2.busy", 32'(busy4), 32'd1);
      cyc = 0;
      while (!done4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("hold2.lat", 32'(cyc), 32'(N4 + 1));
      check("hold2.p", 32'(p4), 32'hFA);
      @(posedge clk); #1;
      check("hold2.done_pulse", 32'(done4), 32'd0);

      // reset in the third RUN cycle of 6 * -6
      @(posedge clk); #1;
      a8 = 8'h06; b8 = 8'hFA; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort.busy_before", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort.busy", 32'(busy8), 32'd0);
      check("abort.done", 32'(done8), 32'd0);
      check("abort.p", 32'(p8), 32'd0);
      #2;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8) dones++;
      end
      check("abort.no_done", 32'(dones), 32'd0);
      check("abort.p_still0", 32'(p8), 32'd0);
      run_op(1'b1, 8'hFD, 8'hFF, 16'h0003, "w8_m3xm1");

      // random operands against a signed reference product
      for (int i = 0; i < 150; i++) begin
         rx = 8'($urandom);
         ry = 8'($urandom);
         sx = rx; sy = ry;
         se = sx * sy;
         run_op(1'b1, rx, ry, se, "rnd8");
      end
      for (int i = 0; i < 40; i++) begin
         rx = 8'($urandom_range(0, 15));
         ry = 8'($urandom_range(0, 15));
         sx4 = rx[3:0]; sy4 = ry[3:0];
         se4 = sx4 * sy4;
         run_op(1'b0, rx, ry, {8'h00, se4}, "rnd4");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (signed two's complement); legal values are even and >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: signed multiplicand; captured on start acceptance.
REQ-006 The block SHALL have port b, input, WIDTH bits: signed multiplier; captured on start acceptance.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new product.
REQ-009 The block SHALL have port p, output, 2*WIDTH bits: signed product a*b.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL capture a and b, clear the accumulator and appended bit q(-1), load the iteration counter with N, and enter RUN.
REQ-012 N SHALL be WIDTH for radix-2 and WIDTH/2 for radix-4 (see REQ-021).
REQ-013 Each RUN cycle SHALL perform one Booth step.
- Radix-2: bit pair {q0,q-1}: 01 adds A, 10 subtracts A, 00/11 does nothing; then arithmetic right shift by 1.
- Counter decrements by 1.
REQ-014 After the step that brings the counter to 0, the FSM SHALL enter DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle with p holding the full 2*WIDTH-bit product, and the FSM SHALL then return to IDLE.
REQ-016 Latency SHALL be fixed: start accepted at edge k gives done=1 in the cycle after edge k+N+1, independent of operand values.
REQ-017 p SHALL hold its value from DONE until the next product is written; p SHALL NOT change during RUN.
REQ-018 start SHALL be ignored in RUN and DONE; no queueing.
REQ-019 Arithmetic SHALL be exact for all operand pairs, including a = b = -2^(WIDTH-1); the accumulator SHALL carry guard bits so that negating the most negative operand cannot overflow.
REQ-020 Changes on a or b after acceptance SHALL NOT affect the result.

Configuration
REQ-021 Radix-4 recoding SHALL be compiled in when macro BOOTH_RADIX4_EN is defined.
- Defined: each RUN step decodes triplet {q1,q0,q-1} into a partial product of 0, ±A or ±2A, followed by an arithmetic right shift by 2; N = WIDTH/2.
- Not defined: radix-2 as in REQ-013; N = WIDTH.
- The interface and the results SHALL be identical in both builds; only latency differs.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, p=0, counter=0 and all internal registers to 0.
REQ-023 If rst_n is asserted mid-RUN or in DONE, the operation SHALL be abandoned, no done pulse SHALL occur, and p SHALL read 0.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-025 With WIDTH=4 and radix-2, a=4'b1001 (-7), b=4'b0001 (1), start pulsed: done appears 5 cycles after acceptance, with p=8'hF9 (-7).
REQ-026 With WIDTH=4, a=5, b=-8: p=8'hD8 (-40); with a=-8, b=-8: p=8'h40 (+64), covering the most-negative corner.
REQ-027 With WIDTH=8, a=-128, b=-128: p=16'h4000; with a=127, b=-128: p=16'hC080; run in both the BOOTH_RADIX4_EN build (done after N+1=5 cycles) and the radix-2 build (done after 9 cycles).
REQ-028 With WIDTH=4, start held high continuously across two operations: the second operation is accepted only in IDLE; a/b toggled during RUN do not change p; exactly one done pulse per product.
REQ-029 With WIDTH=8, rst_n pulsed low in the 3rd RUN cycle of 6*(-6): busy and done read 0 immediately, p reads 0, and no done pulse follows; a new start of -3*(-1) then gives p=16'h0003.
REQ-030 Random regression: 10k signed operand pairs per build, each checked against a reference signed multiply, with the done-latency check of REQ-016 applied to every transaction.
